regm_sb: RTL

- Parametrised successor to the CPU register memory: configurable width, depth and read-port count.
- Two write ports: port 0 is the ALU writeback, port 1 is the load/memory writeback.
- Write-through bypass on every read port.
- Per-register pending scoreboard (busy bits) so the decode stage can stall on RAW hazards from multi-cycle operations.
- Sits between decode (reads, issue) and the writeback stages of the processor pipeline.

---
 rtl/regm_sb_pkg.sv | 11 +
 rtl/regm_sb_rdport.sv | 42 ++++
 rtl/regm_sb.sv | 108 ++++++++++
 3 files changed

// File: rtl/regm_sb_pkg.sv
// Shared defaults for the scoreboarded register memory: geometry and the
// index of the hard-wired zero register.
package regm_sb_pkg;

  localparam int REGM_WIDTH    = 32;
  localparam int REGM_DEPTH    = 32;
  localparam int REGM_AW       = 5;
  localparam int REGM_NREAD    = 3;
  localparam int REGM_ZERO_IDX = 0;

endpackage

// File: rtl/regm_sb_rdport.sv
// One bypassed read path: zero register, then load writeback, then ALU
// writeback, then the stored word gated by its busy bit.
module regm_sb_rdport
  import regm_sb_pkg::*;
#(
  parameter int WIDTH    = REGM_WIDTH,
  parameter int AW       = REGM_AW,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [AW-1:0]    raddr,
  input  logic             wen0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             wen1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [WIDTH-1:0] mem_word,
  input  logic             mem_busy,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // Port 1 is checked before port 0 so the bypass agrees with the write winner.
  always_comb begin
    data  = '0;
    ready = 1'b1;
    if (ZERO_REG && (raddr == AW'(REGM_ZERO_IDX))) begin
      data  = '0;
      ready = 1'b1;
    end else if (wen1 && (waddr1 == raddr)) begin
      data  = wdata1;
      ready = 1'b1;
    end else if (wen0 && (waddr0 == raddr)) begin
      data  = wdata0;
      ready = 1'b1;
    end else begin
      data  = mem_word;
      ready = ~mem_busy;
    end
  end

endmodule

// File: rtl/regm_sb.sv
// Register memory with two writeback ports, bypassed read ports and a
// per-register pending scoreboard for RAW stalls on multi-cycle ops.
module regm_sb
  import regm_sb_pkg::*;
#(
  parameter int WIDTH    = REGM_WIDTH,
  parameter int DEPTH    = REGM_DEPTH,
  parameter int AW       = REGM_AW,
  parameter int NREAD    = REGM_NREAD,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rready,
  input  logic                   wen0,
  input  logic [AW-1:0]          waddr0,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic                   wen1,
  input  logic [AW-1:0]          waddr1,
  input  logic [WIDTH-1:0]       wdata1,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_reg,
  input  logic                   flush,
  output logic                   busy_any,
  output logic [DEPTH-1:0]       busy_vec
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic             busy_any_r;
  logic [DEPTH-1:0] busy_next_s;

  // Busy priority: flush, then a new issue, then a writeback clearing it.
  always_comb begin
    busy_next_s = busy_r;
    for (int r = 0; r < DEPTH; r++) begin
      if (flush) begin
        busy_next_s[r] = 1'b0;
      end else if (issue_en && (issue_reg == AW'(r)) &&
                   !(ZERO_REG && (r == REGM_ZERO_IDX))) begin
        busy_next_s[r] = 1'b1;
      end else if ((wen0 && (waddr0 == AW'(r))) || (wen1 && (waddr1 == AW'(r)))) begin
        busy_next_s[r] = 1'b0;
      end else begin
        busy_next_s[r] = busy_r[r];
      end
    end
  end

  // Register storage; port 1 wins a same-address conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (!(ZERO_REG && (r == REGM_ZERO_IDX))) begin
          if (wen1 && (waddr1 == AW'(r))) begin
            mem_r[r] <= wdata1;
          end else if (wen0 && (waddr0 == AW'(r))) begin
            mem_r[r] <= wdata0;
          end
        end
      end
    end
  end

  // Scoreboard state and its registered summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r     <= '0;
      busy_any_r <= 1'b0;
    end else begin
      busy_r     <= busy_next_s;
      busy_any_r <= |busy_next_s;
    end
  end

  assign busy_vec = busy_r;
  assign busy_any = busy_any_r;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] raddr_s;
    assign raddr_s = raddr[i*AW +: AW];

    regm_sb_rdport #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .raddr    (raddr_s),
      .wen0     (wen0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .wen1     (wen1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .mem_word (mem_r[raddr_s]),
      .mem_busy (busy_r[raddr_s]),
      .data     (rdata[i*WIDTH +: WIDTH]),
      .ready    (rready[i])
    );
  end

endmodule
